control_sequencer: RTL
======================

Name: control_sequencer

Overview:
Hardwired control unit that drives every datapath control strobe for fetch plus register-register ALU instructions. Sits directly upstream of datapath: it consumes the datapath IR contents and produces the Rin/Rout/PCout/MARin/.../ALUop vector that benches currently hand-sequence. One instruction is executed at a time. Each instruction is a fixed T-step sequence selected by the opcode.

Parameters:
NREGS, 16, number of general registers; width of one-hot Rin/Rout
ALUOP_W, 4, width of ALUop bus

Ports:
clock  input  1  system clock, rising edge
clear  input  1  asynchronous, active-low reset
ir  input  32  datapath IR output; fields op=ir[31:27], Ra=ir[26:23], Rb=ir[22:19], Rc=ir[18:15]
stop  input  1  request halt at next instruction boundary
Rin, Rout  output  NREGS  one-hot register load/drive strobes
PCin, PCout, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin  output  1 each  datapath strobes
Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin  output  1 each  Z/HI/LO strobes
ALUop  output  ALUOP_W  ALU function select
ALU_MUL, ALU_DIV  output  1 each  multi-word ALU selects
run  output  1  high while sequencing, low in RESET/HALT
instr_done  output  1  one-cycle pulse on the last step of each instruction

Behaviour:
- States: RESET, T0..T6, HALT. Only state is registered. All outputs are decoded combinationally from state and ir. In RESET every output is 0.
- clear low forces state to RESET immediately, including mid-instruction. The first rising edge with clear high moves to T0.
- Fetch, common to all instructions:
  - T0: PCout, MARin, IncPC, Zlowin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
  - Decode uses ir from T3 onward.
- Opcode to ALUop mapping:
  - add 00011→1, sub 00100→2, and 00101→3, or 00110→4, ror 00111→8, rol 01000→9.
  - shr 01001→5, shra 01010→6, shl 01011→7, neg 10001→10, not 10010→11.
  - mul 01111 and div 10000 use ALU_MUL/ALU_DIV with ALUop=0.
  - nop 11010 and halt 11011 use ALUop=0.
  - Any other opcode is treated as nop.
- Binary ops (Ra = Rb op Rc):
  - T3: Rout[Rb], Yin.
  - T4: Rout[Rc], ALUop, Zlowin.
  - T5: Zlowout, Rin[Ra], instr_done.
  - Then T0.
- neg/not (Ra = op Rb):
  - T3: Rout[Rb], ALUop, Zlowin.
  - T4: Zlowout, Rin[Ra], instr_done.
  - Then T0.
- mul/div (Ra, Rb → HI:LO):
  - T3: Rout[Ra], Yin.
  - T4: Rout[Rb], ALU_MUL or ALU_DIV, Zlowin, Zhighin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin, instr_done.
  - Then T0.
- nop/unknown: T3 with all strobes low except instr_done, then T0.
- halt: T3 asserts instr_done, then HALT.
- HALT: all outputs 0, run=0. HALT is left only via clear.
- stop is sampled only on the instruction_done step:
  - If stop is high there, the next state is HALT, not T0.
  - stop asserted at any other step has no effect until that instruction's done step.
- Rin/Rout are strictly one-hot or zero. Field value ≥ NREGS drives zero (no strobe).
- At most one of Zlowout, Zhighout, MDRout, PCout, and any Rout bit is high in any cycle (single bus driver).
- run=1 in T0..T6.

Test Plan:
1. Reset: hold clear=0 for 2 cycles with arbitrary ir → all outputs 0, run=0. Release → next edge enters T0 with PCout=MARin=IncPC=Zlowin=1.
2. rol R7,R0,R4 (ir=0x43820000):
   - T3: Rout=0x0001, Yin.
   - T4: Rout=0x0010, ALUop=9, Zlowin.
   - T5: Zlowout, Rin=0x0080, instr_done.
   - Then T0.
   - With the datapath attached and R0=9, R4=2 → R7=0x00000024.
3. mul R3,R1 (ir=0x79880000):
   - T3: Rout=0x0008.
   - T4: Rout=0x0002, ALU_MUL, Zlowin, Zhighin.
   - T5: LOin.
   - T6: HIin, instr_done.
   - Instruction is 7 cycles total.
4. halt (ir=0xD8000000) → T3 instr_done, then HALT with run=0 held for 10+ cycles. Only clear restarts at T0.
5. stop raised during T4 of an add → add completes through T5, then HALT. Repeat with stop raised during T0 and dropped before T5 → execution continues to next T0.
6. Async reset: pull clear low mid-T4 of rol, between clock edges → all outputs 0 within the same cycle, and Rin[7] is never asserted.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired control unit: steps fetch plus one register-register ALU instruction
// through T0..T6 and decodes every datapath strobe from the state and the IR.
module control_sequencer #(
    parameter int NREGS   = 16,
    parameter int ALUOP_W = 4
) (
    input  logic               clock,
    input  logic               clear,
    input  logic [31:0]        ir,
    input  logic               stop,
    output logic [NREGS-1:0]   Rin,
    output logic [NREGS-1:0]   Rout,
    output logic               PCin,
    output logic               PCout,
    output logic               IncPC,
    output logic               MARin,
    output logic               MDRin,
    output logic               MDRout,
    output logic               Read,
    output logic               IRin,
    output logic               Yin,
    output logic               Zlowin,
    output logic               Zhighin,
    output logic               Zlowout,
    output logic               Zhighout,
    output logic               HIin,
    output logic               LOin,
    output logic [ALUOP_W-1:0] ALUop,
    output logic               ALU_MUL,
    output logic               ALU_DIV,
    output logic               run,
    output logic               instr_done
);

    // state  | meaning
    // RESET  | held by clear; all outputs low
    // T0     | fetch: PC to MAR, PC+1 into Z
    // T1     | fetch: Z to PC, memory read into MDR
    // T2     | fetch: MDR to IR
    // T3..T6 | execute steps selected by the opcode
    // HALT   | idle until clear
    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        K_NOP, K_BIN, K_UNA, K_MUL, K_DIV, K_HALT
    } kind_t;

    state_t state, state_next;
    kind_t  kind;

    logic [4:0]         op;
    logic [3:0]         ra, rb, rc;
    logic [ALUOP_W-1:0] alu_code;
    logic [NREGS-1:0]   ra_hot, rb_hot, rc_hot;
    logic               done_step;
    logic               unused_ir;

    assign op        = ir[31:27];
    assign ra        = ir[26:23];
    assign rb        = ir[22:19];
    assign rc        = ir[18:15];
    assign unused_ir = ^ir[14:0];

    // Field values that name no register produce no strobe at all.
    function automatic logic [NREGS-1:0] reg_hot(input logic [3:0] f);
        logic [NREGS-1:0] r;
        r = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (int'(f) == i) r[i] = 1'b1;
        end
        return r;
    endfunction

    assign ra_hot = reg_hot(ra);
    assign rb_hot = reg_hot(rb);
    assign rc_hot = reg_hot(rc);

    always_comb begin
        kind     = K_NOP;
        alu_code = '0;
        case (op)
            5'b00011: begin kind = K_BIN;  alu_code = ALUOP_W'(1);  end
            5'b00100: begin kind = K_BIN;  alu_code = ALUOP_W'(2);  end
            5'b00101: begin kind = K_BIN;  alu_code = ALUOP_W'(3);  end
            5'b00110: begin kind = K_BIN;  alu_code = ALUOP_W'(4);  end
            5'b00111: begin kind = K_BIN;  alu_code = ALUOP_W'(8);  end
            5'b01000: begin kind = K_BIN;  alu_code = ALUOP_W'(9);  end
            5'b01001: begin kind = K_BIN;  alu_code = ALUOP_W'(5);  end
            5'b01010: begin kind = K_BIN;  alu_code = ALUOP_W'(6);  end
            5'b01011: begin kind = K_BIN;  alu_code = ALUOP_W'(7);  end
            5'b10001: begin kind = K_UNA;  alu_code = ALUOP_W'(10); end
            5'b10010: begin kind = K_UNA;  alu_code = ALUOP_W'(11); end
            5'b01111: kind = K_MUL;
            5'b10000: kind = K_DIV;
            5'b11011: kind = K_HALT;
            default:  kind = K_NOP;
        endcase
    end

    always_comb begin
        done_step = 1'b0;
        case (state)
            S_T3:    done_step = (kind == K_NOP) || (kind == K_HALT);
            S_T4:    done_step = (kind == K_UNA);
            S_T5:    done_step = (kind == K_BIN);
            S_T6:    done_step = (kind == K_MUL) || (kind == K_DIV);
            default: done_step = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) state <= S_RESET;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (done_step) begin
            state_next = (kind == K_HALT || stop) ? S_HALT : S_T0;
        end else begin
            case (state)
                S_RESET: state_next = S_T0;
                S_T0:    state_next = S_T1;
                S_T1:    state_next = S_T2;
                S_T2:    state_next = S_T3;
                S_T3:    state_next = S_T4;
                S_T4:    state_next = S_T5;
                S_T5:    state_next = S_T6;
                S_T6:    state_next = S_T0;
                S_HALT:  state_next = S_HALT;
                default: state_next = S_RESET;
            endcase
        end
    end

    always_comb begin
        Rin        = '0;
        Rout       = '0;
        PCin       = 1'b0;
        PCout      = 1'b0;
        IncPC      = 1'b0;
        MARin      = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        Read       = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        Zlowin     = 1'b0;
        Zhighin    = 1'b0;
        Zlowout    = 1'b0;
        Zhighout   = 1'b0;
        HIin       = 1'b0;
        LOin       = 1'b0;
        ALUop      = '0;
        ALU_MUL    = 1'b0;
        ALU_DIV    = 1'b0;
        run        = 1'b0;
        instr_done = 1'b0;
        case (state)
            S_T0: begin
                run    = 1'b1;
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                Zlowin = 1'b1;
            end
            S_T1: begin
                run     = 1'b1;
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                run    = 1'b1;
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                run        = 1'b1;
                instr_done = done_step;
                case (kind)
                    K_BIN: begin
                        Rout = rb_hot;
                        Yin  = 1'b1;
                    end
                    K_UNA: begin
                        Rout   = rb_hot;
                        ALUop  = alu_code;
                        Zlowin = 1'b1;
                    end
                    K_MUL, K_DIV: begin
                        Rout = ra_hot;
                        Yin  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                run        = 1'b1;
                instr_done = done_step;
                case (kind)
                    K_BIN: begin
                        Rout   = rc_hot;
                        ALUop  = alu_code;
                        Zlowin = 1'b1;
                    end
                    K_UNA: begin
                        Zlowout = 1'b1;
                        Rin     = ra_hot;
                    end
                    K_MUL, K_DIV: begin
                        Rout    = rb_hot;
                        ALU_MUL = (kind == K_MUL);
                        ALU_DIV = (kind == K_DIV);
                        Zlowin  = 1'b1;
                        Zhighin = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                run        = 1'b1;
                instr_done = done_step;
                case (kind)
                    K_BIN: begin
                        Zlowout = 1'b1;
                        Rin     = ra_hot;
                    end
                    K_MUL, K_DIV: begin
                        Zlowout = 1'b1;
                        LOin    = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                run        = 1'b1;
                instr_done = done_step;
                if (kind == K_MUL || kind == K_DIV) begin
                    Zhighout = 1'b1;
                    HIin     = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
